// File: rtl/load_store_unit.sv
// Load/store unit: turns decoder load/store requests into single-beat data-bus
// accesses. It builds the byte enables and lane-replicated store data, formats
// load data with zero or sign extension, and aborts an access when the bus does
// not acknowledge within TIMEOUT_CYCLES request cycles.
//
// Bus handshake: bus_req_out is high for every cycle the unit sits in REQ, and
// the address, data, byte enables and write flag stay constant for that whole
// period. The access completes on the first rising edge in REQ that sees
// bus_ack_in high. bus_ack_in is ignored in every other state.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [3:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        rdata_valid_out,
    output logic        misaligned_out,
    output logic        bus_error_out,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    output logic [3:0]  bus_be_out,
    input  logic        bus_ack_in,
    input  logic [31:0] bus_rdata_in,
    output logic [1:0]  dbg_state_out
);

    // Counter value on the last REQ cycle before an abort.
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_cnt;
    logic        r_we;
    logic        r_zext;
    logic        r_half;
    logic        r_byte;
    logic [1:0]  r_lane;
    logic        r_bus_req;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic [31:0] r_rdata;

    logic        w_active;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_accept;
    logic        w_ack;
    logic        w_expire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_lane_data;
    logic [31:0] w_load_data;

    // Any width code other than half or byte is a word access.
    assign w_active     = mem_read_in | mem_write_in;
    assign w_is_half    = (mem_width_in == 4'b0101);
    assign w_is_byte    = (mem_width_in == 4'b1010);
    assign w_is_word    = ~(w_is_half | w_is_byte);
    assign w_misaligned = (w_is_half & addr_in[0]) |
                          (w_is_word & (addr_in[1:0] != 2'b00));
    assign w_accept     = (r_state == IDLE) & w_active & ~w_misaligned;
    assign w_ack        = (r_state == REQ) & bus_ack_in;
    assign w_expire     = (r_state == REQ) & ~bus_ack_in & (r_cnt == LP_LAST);

    // Store formatting: byte enables and data replicated into every lane.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_in;
        if (w_is_byte) begin
            w_be    = 4'b0001 << addr_in[1:0];
            w_wdata = {4{wdata_in[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << addr_in[1:0];
            w_wdata = {2{wdata_in[15:0]}};
        end
    end

    // Load formatting: shift the addressed lane down, then extend it.
    always_comb begin
        w_lane_data = bus_rdata_in >> {r_lane, 3'b000};
        w_load_data = w_lane_data;
        if (r_byte) begin
            w_load_data = {{24{~r_zext & w_lane_data[7]}}, w_lane_data[7:0]};
        end else if (r_half) begin
            w_load_data = {{16{~r_zext & w_lane_data[15]}}, w_lane_data[15:0]};
        end
    end

    // Next-state and handshake outputs; the request inputs only matter in IDLE.
    always_comb begin
        w_next_state    = r_state;
        stall_out       = 1'b0;
        misaligned_out  = 1'b0;
        rdata_valid_out = 1'b0;
        bus_error_out   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_active) begin
                    if (w_misaligned) begin
                        misaligned_out = 1'b1;
                    end else begin
                        stall_out    = 1'b1;
                        w_next_state = REQ;
                    end
                end
            end
            REQ: begin
                stall_out = 1'b1;
                if (w_ack) begin
                    w_next_state = RESP;
                end else if (w_expire) begin
                    w_next_state = ERR;
                end
            end
            RESP: begin
                rdata_valid_out = ~r_we;
                w_next_state    = IDLE;
            end
            ERR: begin
                bus_error_out = 1'b1;
                w_next_state  = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Access latch, bus payload, timeout counter and load result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= 8'd0;
            r_we        <= 1'b0;
            r_zext      <= 1'b0;
            r_half      <= 1'b0;
            r_byte      <= 1'b0;
            r_lane      <= 2'b00;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
            r_rdata     <= 32'd0;
        end else begin
            r_bus_req <= (w_next_state == REQ);
            if (w_accept) begin
                r_cnt       <= 8'd0;
                r_we        <= mem_write_in;
                r_zext      <= mem_zero_extend_in;
                r_half      <= w_is_half;
                r_byte      <= w_is_byte;
                r_lane      <= addr_in[1:0];
                r_bus_addr  <= {addr_in[31:2], 2'b00};
                r_bus_wdata <= w_wdata;
                r_bus_be    <= w_be;
            end else if ((r_state == REQ) && !bus_ack_in && !w_expire) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ack && !r_we) begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign bus_req_out   = r_bus_req;
    assign bus_we_out    = r_we;
    assign bus_addr_out  = r_bus_addr;
    assign bus_wdata_out = r_bus_wdata;
    assign bus_be_out    = r_bus_be;
    assign rdata_out     = r_rdata;
    assign dbg_state_out = r_state;

endmodule
